// File: rtl/cmd_dispatcher.sv
// Command dispatcher: parses header/payload words, updates draw registers,
// starts action units and reports errors and completed commands.
module cmd_dispatcher #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_PAYLOAD = 8,
    parameter int unsigned NUM_UNITS   = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic                          cmd_ready,
    output logic [NUM_UNITS-1:0]          unit_start,
    input  logic [NUM_UNITS-1:0]          unit_done,
    output logic [MAX_PAYLOAD*DATA_W-1:0] param_data,
    output logic [DATA_W-1:0]             color,
    output logic [4*DATA_W-1:0]           viewport,
    output logic                          busy,
    output logic                          err_valid,
    output logic [1:0]                    err_code,
    output logic [15:0]                   cmd_count
);

    localparam int unsigned IDX_W  = $clog2(MAX_PAYLOAD);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_COLOR = 8'h10;
    localparam logic [7:0] OP_VIEW  = 8'h11;

    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_LENGTH  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_PAYLOAD, S_EXEC, S_WAIT, S_DRAIN
    } state_t;

    state_t                r_state;
    logic [7:0]            r_opcode;
    logic [15:0]           r_len;
    logic [15:0]           r_count;
    logic [WCNT_W-1:0]     r_wait_cnt;
    logic [DATA_W-1:0]     r_buf [MAX_PAYLOAD];
    logic [DATA_W-1:0]     r_color;
    logic [4*DATA_W-1:0]   r_viewport;
    logic [NUM_UNITS-1:0]  r_unit_start;
    logic                  r_err_valid;
    logic [1:0]            r_err_code;
    logic [15:0]           r_cmd_count;

    logic                  w_accept;
    logic [7:0]            w_hdr_op;
    logic [15:0]           w_hdr_len;
    logic                  w_done;

    function automatic logic is_unit(input logic [7:0] op);
        return (op != 8'd0) && (op <= 8'(NUM_UNITS));
    endfunction

    function automatic logic [NUM_UNITS-1:0] start_vec(input logic [7:0] op);
        return is_unit(op) ? (NUM_UNITS'(1) << (op - 8'd1)) : '0;
    endfunction

    assign cmd_ready  = (r_state == S_IDLE) || (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
    assign busy       = (r_state != S_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_hdr_op   = cmd_data[31:24];
    assign w_hdr_len  = cmd_data[15:0];
    // Only the done bit of the unit that this command started matters.
    assign w_done     = |(unit_done & start_vec(r_opcode));

    assign unit_start = r_unit_start;
    assign color      = r_color;
    assign viewport   = r_viewport;
    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign cmd_count  = r_cmd_count;

    always_comb begin
        param_data = '0;
        for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
            param_data[i*DATA_W +: DATA_W] = r_buf[i];
        end
    end

    // Dispatcher FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_opcode     <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_wait_cnt   <= '0;
            r_color      <= '0;
            r_viewport   <= '0;
            r_unit_start <= '0;
            r_err_valid  <= 1'b0;
            r_err_code   <= '0;
            r_cmd_count  <= '0;
            for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_unit_start <= '0;
            r_err_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opcode <= w_hdr_op;
                        r_len    <= w_hdr_len;
                        r_count  <= '0;
                        if (w_hdr_len == 16'd0) begin
                            r_state      <= S_EXEC;
                            r_unit_start <= start_vec(w_hdr_op);
                        end else if (w_hdr_len <= 16'(MAX_PAYLOAD)) begin
                            r_state <= S_PAYLOAD;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_accept) begin
                        r_buf[r_count[IDX_W-1:0]] <= cmd_data;
                        r_count <= r_count + 16'd1;
                        if (r_count == r_len - 16'd1) begin
                            r_state      <= S_EXEC;
                            r_unit_start <= start_vec(r_opcode);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        r_count <= r_count + 16'd1;
                        if (r_count == r_len - 16'd1) begin
                            r_state     <= S_IDLE;
                            r_err_valid <= 1'b1;
                            r_err_code  <= ERR_LENGTH;
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    if (is_unit(r_opcode)) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end else begin
                        case (r_opcode)
                            OP_NOP: r_cmd_count <= r_cmd_count + 16'd1;
                            OP_COLOR: begin
                                if (r_len >= 16'd1) begin
                                    r_color     <= r_buf[0];
                                    r_cmd_count <= r_cmd_count + 16'd1;
                                end else begin
                                    r_err_valid <= 1'b1;
                                    r_err_code  <= ERR_LENGTH;
                                end
                            end
                            OP_VIEW: begin
                                if (r_len >= 16'd4) begin
                                    r_viewport  <= {r_buf[3], r_buf[2], r_buf[1], r_buf[0]};
                                    r_cmd_count <= r_cmd_count + 16'd1;
                                end else begin
                                    r_err_valid <= 1'b1;
                                    r_err_code  <= ERR_LENGTH;
                                end
                            end
                            default: begin
                                r_err_valid <= 1'b1;
                                r_err_code  <= ERR_OPCODE;
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state     <= S_IDLE;
                        r_cmd_count <= r_cmd_count + 16'd1;
                    end else if (r_wait_cnt == WCNT_W'(TIMEOUT_CYC - 1)) begin
                        r_state     <= S_IDLE;
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed self-checking bench for cmd_dispatcher (TIMEOUT_CYC=16).
module tb_cmd_dispatcher;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MAX_PAYLOAD = 8;
    localparam int unsigned NUM_UNITS   = 4;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic                          clk;
    logic                          rst_n;
    logic                          cmd_valid;
    logic [DATA_W-1:0]             cmd_data;
    logic                          cmd_ready;
    logic [NUM_UNITS-1:0]          unit_start;
    logic [NUM_UNITS-1:0]          unit_done;
    logic [MAX_PAYLOAD*DATA_W-1:0] param_data;
    logic [DATA_W-1:0]             color;
    logic [4*DATA_W-1:0]           viewport;
    logic                          busy;
    logic                          err_valid;
    logic [1:0]                    err_code;
    logic [15:0]                   cmd_count;

    int n_checks = 0;
    int n_errors = 0;
    int waits;

    cmd_dispatcher #(
        .DATA_W(DATA_W), .MAX_PAYLOAD(MAX_PAYLOAD),
        .NUM_UNITS(NUM_UNITS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .unit_start(unit_start), .unit_done(unit_done),
        .param_data(param_data), .color(color), .viewport(viewport), .busy(busy),
        .err_valid(err_valid), .err_code(err_code), .cmd_count(cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word, wait (bounded) for ready, return #1 after the accepting edge.
    task automatic send_word(input logic [31:0] data, output int n_wait);
        n_wait    = 0;
        cmd_valid = 1'b1;
        cmd_data  = data;
        while (!cmd_ready && n_wait < 50) begin
            step(1);
            n_wait++;
        end
        if (n_wait >= 50) chk("ready_timeout", 256'(n_wait), 256'(0));
        step(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        unit_done = '0;
        step(2);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_ready", 256'(cmd_ready), 256'(1));
        chk("rst_start", 256'(unit_start), 256'(0));
        chk("rst_err", 256'({err_valid, err_code}), 256'(0));
        chk("rst_count", 256'(cmd_count), 256'(0));
        chk("rst_regs", 256'({color, viewport}), 256'(0));
        chk("rst_param", 256'(param_data), 256'(0));
        rst_n = 1'b1;
        step(1);

        // SET_COLOR with one payload word
        send_word(32'h1000_0001, waits);
        chk("color_hdr_busy", 256'({busy, cmd_ready}), 256'(2'b11));
        send_word(32'h00FF_00FF, waits);
        chk("color_exec_ready", 256'(cmd_ready), 256'(0));
        chk("color_param0", 256'(param_data[31:0]), 256'(32'h00FF_00FF));
        chk("color_exec_start", 256'(unit_start), 256'(0));
        step(1);
        chk("color_value", 256'(color), 256'(32'h00FF_00FF));
        chk("color_count", 256'(cmd_count), 256'(1));
        chk("color_idle", 256'({busy, err_valid}), 256'(0));

        // Unit 2 start; a stray done from unit 1 is ignored
        send_word(32'h0200_0000, waits);
        chk("u2_start", 256'(unit_start), 256'(4'b0010));
        step(1);
        chk("u2_start_once", 256'(unit_start), 256'(0));
        unit_done = 4'b0001;
        step(1);
        unit_done = 4'b0000;
        chk("u2_other_done", 256'(busy), 256'(1));
        step(2);
        chk("u2_busy", 256'({busy, unit_start}), 256'({1'b1, 4'b0000}));
        unit_done = 4'b0010;
        step(1);
        unit_done = 4'b0000;
        chk("u2_done_idle", 256'(busy), 256'(0));
        chk("u2_count", 256'(cmd_count), 256'(2));

        // Oversized SET_VIEWPORT is drained
        send_word(32'h1100_0009, waits);
        chk("drain_state", 256'({busy, cmd_ready}), 256'(2'b11));
        for (int i = 0; i < 8; i++) send_word(32'hDEAD_0000 + 32'(i), waits);
        chk("drain_no_err_yet", 256'(err_valid), 256'(0));
        send_word(32'hDEAD_0008, waits);
        chk("drain_err", 256'({err_valid, err_code}), 256'({1'b1, 2'd2}));
        chk("drain_idle", 256'(busy), 256'(0));
        chk("drain_view", 256'(viewport), 256'(0));
        chk("drain_param", 256'(param_data[31:0]), 256'(32'h00FF_00FF));
        step(1);
        chk("drain_err_pulse", 256'({err_valid, err_code}), 256'({1'b0, 2'd2}));
        chk("drain_count", 256'(cmd_count), 256'(2));

        // Valid SET_VIEWPORT
        send_word(32'h1100_0004, waits);
        send_word(32'd1, waits);
        send_word(32'd2, waits);
        send_word(32'd3, waits);
        send_word(32'd4, waits);
        step(1);
        chk("view_value", 256'(viewport), 256'({32'd4, 32'd3, 32'd2, 32'd1}));
        chk("view_count", 256'(cmd_count), 256'(3));

        // SET_VIEWPORT too short
        send_word(32'h1100_0002, waits);
        send_word(32'h0000_00AA, waits);
        send_word(32'h0000_00BB, waits);
        step(1);
        chk("view_short_err", 256'({err_valid, err_code}), 256'({1'b1, 2'd2}));
        chk("view_short_keep", 256'(viewport), 256'({32'd4, 32'd3, 32'd2, 32'd1}));
        chk("view_short_param", 256'(param_data[95:0]), 256'({32'd3, 32'hBB, 32'hAA}));
        chk("view_short_count", 256'(cmd_count), 256'(3));

        // Unit 1 timeout (done outside WAIT ignored)
        unit_done = 4'b0001;
        step(1);
        unit_done = 4'b0000;
        send_word(32'h0100_0000, waits);
        chk("to_start", 256'(unit_start), 256'(4'b0001));
        step(1);
        step(15);
        chk("to_still_wait", 256'({busy, err_valid}), 256'(2'b10));
        step(1);
        chk("to_err", 256'({err_valid, err_code}), 256'({1'b1, 2'd3}));
        chk("to_idle", 256'(busy), 256'(0));
        chk("to_count", 256'(cmd_count), 256'(3));

        // Unknown opcode then back-to-back header
        send_word(32'h7F00_0000, waits);
        chk("unk_start", 256'(unit_start), 256'(0));
        step(1);
        chk("unk_err", 256'({err_valid, err_code}), 256'({1'b1, 2'd1}));
        send_word(32'h1000_0001, waits);
        chk("b2b_nowait", 256'(waits), 256'(0));
        chk("b2b_payload", 256'(busy), 256'(1));
        send_word(32'h1234_5678, waits);
        step(1);
        chk("b2b_color", 256'(color), 256'(32'h1234_5678));
        chk("b2b_count", 256'(cmd_count), 256'(4));

        // NOP, then zero-length SET_COLOR
        send_word(32'h0000_0000, waits);
        step(1);
        chk("nop_count", 256'({busy, err_valid, cmd_count}), 256'({2'b00, 16'd5}));
        send_word(32'h1000_0000, waits);
        step(1);
        chk("color0_err", 256'({err_valid, err_code}), 256'({1'b1, 2'd2}));
        chk("color0_keep", 256'({color, cmd_count}), 256'({32'h1234_5678, 16'd5}));

        // Reset during WAIT
        send_word(32'h0300_0000, waits);
        chk("rw_start", 256'(unit_start), 256'(4'b0100));
        step(3);
        rst_n = 1'b0;
        #2;
        chk("rw_busy", 256'({busy, cmd_ready}), 256'(2'b01));
        chk("rw_regs", 256'({color, viewport, cmd_count, err_code, err_valid}), 256'(0));
        chk("rw_param", 256'(param_data), 256'(0));
        step(1);
        rst_n = 1'b1;
        send_word(32'h1000_0001, waits);
        chk("rw_hdr_nowait", 256'(waits), 256'(0));
        send_word(32'hCAFE_F00D, waits);
        step(1);
        chk("rw_color", 256'({color, cmd_count}), 256'({32'hCAFE_F00D, 16'd1}));
        chk("rw_noerr", 256'(err_valid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmd_dispatcher.md
CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

Interface
REQ-001 Parameter DATA_W, default 32, command word and payload word width (min 32).
REQ-002 Parameter MAX_PAYLOAD, default 8, payload buffer depth in words (min 4).
REQ-003 Parameter NUM_UNITS, default 4, number of action units, 1..15.
REQ-004 Parameter TIMEOUT_CYC, default 65535, maximum WAIT cycles before abort (min 2).
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  in  1  command word valid.
REQ-008 cmd_data  in  DATA_W  header or payload word; header: [31:24] opcode, [15:0] payload length.
REQ-009 cmd_ready  out  1  word accepted when cmd_valid and cmd_ready are both high.
REQ-010 unit_start  out  NUM_UNITS  one-cycle start pulse per unit.
REQ-011 unit_done  in  NUM_UNITS  completion pulse or level per unit.
REQ-012 param_data  out  MAX_PAYLOAD*DATA_W  payload buffer, word i at bits [i*DATA_W +: DATA_W].
REQ-013 color  out  DATA_W  current draw color.
REQ-014 viewport  out  4*DATA_W  {ymax,xmax,ymin,xmin}, xmin in the LSBs.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 err_valid  out  1  one-cycle error pulse.
REQ-017 err_code  out  2  1=unknown opcode, 2=bad length, 3=timeout; held until the next error.
REQ-018 cmd_count  out  16  completed-command counter.

Function
REQ-019 States SHALL be IDLE, PAYLOAD, EXEC, WAIT and DRAIN.
REQ-020 cmd_ready SHALL be high in IDLE, PAYLOAD and DRAIN, and low in EXEC and WAIT.
REQ-021 IDLE, header accepted: latch opcode/length, clear word counter; length 0 -> EXEC, length 1..MAX_PAYLOAD -> PAYLOAD, length > MAX_PAYLOAD -> DRAIN.
REQ-022 PAYLOAD: each accepted word SHALL be written to buffer[count] and count incremented; acceptance of word length-1 -> EXEC next cycle.
REQ-023 DRAIN: accepted words SHALL be discarded; after the last word, pulse err_valid with code 2 and return to IDLE, with no unit start and no register write.
REQ-024 Valid opcodes: 0x00 NOP; 0x01..NUM_UNITS start unit opcode-1; 0x10 SET_COLOR (length >= 1); 0x11 SET_VIEWPORT (length >= 4).
REQ-025 EXEC SHALL last exactly one cycle; unit opcode: unit_start[opcode-1] high for that cycle -> WAIT.
REQ-026 EXEC SET_COLOR: color <= buffer[0] at the EXEC clock edge -> IDLE.
REQ-027 EXEC SET_VIEWPORT: viewport <= buffer[0..3] at the EXEC clock edge -> IDLE.
REQ-028 EXEC NOP -> IDLE.
REQ-029 EXEC SET_COLOR or SET_VIEWPORT with length below the required minimum: err code 2, no register write -> IDLE.
REQ-030 EXEC unknown opcode: err code 1 -> IDLE.
REQ-031 unit_done SHALL be ignored outside WAIT; other units' done bits SHALL be ignored in WAIT.
REQ-032 WAIT: unit_done[opcode-1] high -> IDLE next cycle; the WAIT cycle counter SHALL be cleared on WAIT entry.
REQ-033 WAIT timeout: counter reaching TIMEOUT_CYC without done -> err code 3 -> IDLE.
REQ-034 cmd_count SHALL increment by 1 on each error-free return to IDLE and wrap 0xFFFF -> 0x0000.
REQ-035 param_data SHALL change only on accepted PAYLOAD words, so it is stable from EXEC through WAIT.
REQ-036 Header-to-start latency SHALL be 1 cycle for a length-0 command and 1 cycle after the last payload word otherwise.
REQ-037 Back-to-back: a header presented in the cycle after the return to IDLE SHALL be accepted without a bubble.

Reset
REQ-038 Asynchronous assertion SHALL force IDLE; unit_start, err_valid, err_code, cmd_count, color, viewport, buffer and counters SHALL all be 0.
REQ-039 Reset mid-operation SHALL abandon the command with no completion or error reported; cmd_ready SHALL be high in the first cycle after release.

Verification
REQ-040 Header 0x10000001 then 0x00FF00FF -> color=0x00FF00FF one cycle after the payload word, cmd_count=1, no unit_start.
REQ-041 Header 0x02000000, unit_done[1] asserted 5 cycles after start -> unit_start=4'b0010 for exactly one cycle, busy high until done, then IDLE.
REQ-042 Header 0x11000009 (MAX_PAYLOAD=8) followed by 9 words -> all 9 words accepted, err_code=2 pulsed once, viewport unchanged.
REQ-043 Header 0x01000000 with unit_done tied low, TIMEOUT_CYC=16 -> err_code=3 after 16 WAIT cycles, cmd_count unchanged.
REQ-044 Header 0x7F000000 -> err_code=1, followed immediately by header 0x10000001 accepted in the next cycle.
REQ-045 rst_n pulsed low during WAIT -> all outputs return to reset values, next header accepted normally.
